// File: rtl/dds_ddc_center_mul_rs_if.sv
// ----------------------------------------------------------------------------
// dds_ddc_center_mul_rs_if
//
// Bundle of the data-path and control signals of dds_ddc_center_mul_rs.
// The producer/consumer side uses the master modport, the multiplier itself
// uses the slave modport.
//
// Signals (directions as seen from the slave / multiplier):
//   ce         in   pipeline enable, low holds every pipeline register
//   in_valid   in   qualifies din0 / din1 / in_tag
//   din0       in   unsigned operand, A_WIDTH bits
//   din1       in   signed operand, B_WIDTH bits
//   in_tag     in   sideband tag, TAG_WIDTH bits
//   sat_clr    in   synchronous clear of sat_cnt, independent of ce
//   out_valid  out  result qualifier
//   dout       out  requantised signed result, OUT_WIDTH bits
//   out_tag    out  in_tag delayed in lockstep with the data
//   sat        out  current valid output sample was clipped
//   sat_cnt    out  saturating count of clipped valid outputs
// ----------------------------------------------------------------------------
interface dds_ddc_center_mul_rs_if #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 18,
  parameter int OUT_WIDTH = 18,
  parameter int TAG_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) ();

  logic                        ce;
  logic                        in_valid;
  logic        [A_WIDTH-1:0]   din0;
  logic signed [B_WIDTH-1:0]   din1;
  logic        [TAG_WIDTH-1:0] in_tag;
  logic                        sat_clr;

  logic                        out_valid;
  logic signed [OUT_WIDTH-1:0] dout;
  logic        [TAG_WIDTH-1:0] out_tag;
  logic                        sat;
  logic        [CNT_WIDTH-1:0] sat_cnt;

  modport master (
    output ce, in_valid, din0, din1, in_tag, sat_clr,
    input  out_valid, dout, out_tag, sat, sat_cnt
  );

  modport slave (
    input  ce, in_valid, din0, din1, in_tag, sat_clr,
    output out_valid, dout, out_tag, sat, sat_cnt
  );

endinterface

// File: rtl/dds_ddc_center_mul_rs.sv
// ----------------------------------------------------------------------------
// dds_ddc_center_mul_rs
//
// Pipelined unsigned x signed multiplier for the DDC centre path. The full
// A_WIDTH+B_WIDTH product is arithmetically right-shifted by SHIFT, optionally
// rounded, and saturated to a signed OUT_WIDTH result. A valid/tag sideband
// travels in lockstep with the data, and a sticky-at-max counter records how
// many valid output samples were clipped.
//
// Pipeline (every register advances only while ce = 1):
//   stage 1              : operands, valid and tag registered
//   stage 2              : exact full product
//   stage 3..NUM_STAGE-1 : pure delay, free for DSP/fabric retiming
//   stage NUM_STAGE      : shift, round, saturate, register outputs
// A sample accepted at ce-edge k is on the outputs after ce-edge
// k+NUM_STAGE-1.
//
// Build option:
//   DDS_DDC_MUL_ROUND_EN  defined   : round half up before the shift
//                         undefined : truncate toward minus infinity
//   Latency is the same in both builds.
//
// Ports:
//   clk    clock, single domain
//   reset  asynchronous, active-high; clears all valid bits and outputs
//   bus    dds_ddc_center_mul_rs_if.slave (ce, in_valid, din0, din1, in_tag,
//          sat_clr, out_valid, dout, out_tag, sat, sat_cnt)
//
// Parameter constraints: NUM_STAGE >= 3, 0 <= SHIFT <= A_WIDTH+B_WIDTH-2,
// OUT_WIDTH <= A_WIDTH+B_WIDTH-SHIFT.
// ----------------------------------------------------------------------------
module dds_ddc_center_mul_rs #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 18,
  parameter int OUT_WIDTH = 18,
  parameter int SHIFT     = 15,
  parameter int NUM_STAGE = 4,
  parameter int TAG_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input logic                    clk,
  input logic                    reset,
  dds_ddc_center_mul_rs_if.slave bus
);

  localparam int PW = A_WIDTH + B_WIDTH;  // exact product width
  localparam int DW = NUM_STAGE - 2;      // stages 2..NUM_STAGE-1

  // --------------------------------------------------------------------------
  // Stage 1: operand capture
  // --------------------------------------------------------------------------
  logic        [A_WIDTH-1:0]   a_q;
  logic signed [B_WIDTH-1:0]   b_q;
  logic        [TAG_WIDTH-1:0] tag_s1;
  logic                        v_s1;

  // --------------------------------------------------------------------------
  // Stage 2..NUM_STAGE-1: product plus retiming delay line. Index 0 holds the
  // freshly formed product, index DW-1 feeds the output stage.
  // --------------------------------------------------------------------------
  logic signed [PW-1:0]        p_pipe   [DW];
  logic        [TAG_WIDTH-1:0] tag_pipe [DW];
  logic        [DW-1:0]        v_pipe;

  // Both operands are extended to the full product width so the multiply is
  // a plain signed PW x PW -> PW operation; the true product always fits.
  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] prod;

  assign a_ext = {{B_WIDTH{1'b0}}, a_q};
  assign b_ext = {{A_WIDTH{b_q[B_WIDTH-1]}}, b_q};
  assign prod  = a_ext * b_ext;

  // NOTE: operand, product and tag registers carry no reset: their contents
  // are only meaningful under a valid bit, and leaving them unreset lets the
  // multiplier map onto DSP input/output registers.
  always_ff @(posedge clk) begin
    if (bus.ce) begin
      a_q         <= bus.din0;
      b_q         <= bus.din1;
      tag_s1      <= bus.in_tag;
      p_pipe[0]   <= prod;
      tag_pipe[0] <= tag_s1;
      for (int i = 1; i < DW; i++) begin
        p_pipe[i]   <= p_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  // Valid bits do reset, so in-flight samples are discarded on reset and no
  // stale out_valid can appear after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_s1   <= 1'b0;
      v_pipe <= '0;
    end else if (bus.ce) begin
      v_s1      <= bus.in_valid;
      v_pipe[0] <= v_s1;
      for (int i = 1; i < DW; i++) begin
        v_pipe[i] <= v_pipe[i-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Final stage: shift / round / saturate
  // --------------------------------------------------------------------------
  // One extra bit of headroom so the rounding add can never wrap.
  logic signed [PW:0] p_ext;
  logic signed [PW:0] q;

  assign p_ext = {p_pipe[DW-1][PW-1], p_pipe[DW-1]};

`ifdef DDS_DDC_MUL_ROUND_EN
  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [PW:0] HALF = (PW+1)'(1) <<< (SHIFT - 1);
      assign q = (p_ext + HALF) >>> SHIFT;
    end else begin : g_no_shift
      assign q = p_ext;
    end
  endgenerate
`else
  assign q = p_ext >>> SHIFT;
`endif

  // q fits the output range exactly when every bit from the output sign bit
  // upward is identical; otherwise clip toward the sign of q.
  logic [PW-OUT_WIDTH+1:0] q_upper;
  logic                    ovf;
  logic [OUT_WIDTH-1:0]    clip_val;
  logic [OUT_WIDTH-1:0]    d_next;
  logic                    v_last;

  assign q_upper  = q[PW:OUT_WIDTH-1];
  assign ovf      = ~((&q_upper) | ~(|q_upper));
  assign clip_val = {q[PW], {(OUT_WIDTH-1){~q[PW]}}};
  assign d_next   = ovf ? clip_val : q[OUT_WIDTH-1:0];
  assign v_last   = v_pipe[DW-1];

  // NOTE: every register in this file is written with non-blocking
  // assignments so all stages sample their inputs from before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.dout      <= '0;
      bus.out_tag   <= '0;
      bus.sat       <= 1'b0;
    end else if (bus.ce) begin
      bus.out_valid <= v_last;
      bus.dout      <= d_next;
      bus.out_tag   <= tag_pipe[DW-1];
      // Invalid beats still flow through dout/out_tag but never flag sat.
      bus.sat       <= v_last & ovf;
    end
  end

  // --------------------------------------------------------------------------
  // Saturation event counter: sticks at all-ones, clear has priority and is
  // honoured even while ce is low.
  // --------------------------------------------------------------------------
  logic sat_evt;

  assign sat_evt = bus.ce & v_last & ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.sat_cnt <= '0;
    end else if (bus.sat_clr) begin
      bus.sat_cnt <= '0;
    end else if (sat_evt && (bus.sat_cnt != {CNT_WIDTH{1'b1}})) begin
      bus.sat_cnt <= bus.sat_cnt + CNT_WIDTH'(1);
    end
  end

endmodule
